// File: rtl/exec_txn_scoreboard_if.sv
// exec_txn_scoreboard_if: bundles the expected-transaction push port, the tapped exec memory signals and the scoreboard outputs
`timescale 1ns/1ps
interface exec_txn_scoreboard_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
);
    localparam int LW = $clog2(DEPTH) + 1;
    logic                  exp_valid;
    logic                  exp_ready;
    logic                  exp_is_wr;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  exec_rd_req;
    logic [ADDR_WIDTH-1:0] exec_rd_addr;
    logic                  exec_wr_req;
    logic [ADDR_WIDTH-1:0] exec_wr_addr;
    logic [DATA_WIDTH-1:0] exec_wr_data;
    logic                  stall;
    logic                  err_valid;
    logic [2:0]            err_code;
    logic [CNT_WIDTH-1:0]  match_cnt;
    logic [CNT_WIDTH-1:0]  err_cnt;
    logic [LW-1:0]         q_level;
    logic                  busy;
    modport master (
        output exp_valid, exp_is_wr, exp_addr, exp_data,
        output exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data, stall,
        input  exp_ready, err_valid, err_code, match_cnt, err_cnt, q_level, busy
    );
    modport slave (
        input  exp_valid, exp_is_wr, exp_addr, exp_data,
        input  exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data, stall,
        output exp_ready, err_valid, err_code, match_cnt, err_cnt, q_level, busy
    );
endinterface

// File: rtl/exec_txn_scoreboard.sv
// exec_txn_scoreboard: in-order compare of exec memory traffic against an expected queue, plus stall-window timeout
`timescale 1ns/1ps
module exec_txn_scoreboard #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input logic                  clk,
    input logic                  reset_n,
    exec_txn_scoreboard_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] E_MISMATCH = 3'd1;
    localparam logic [2:0] E_UNEXP    = 3'd2;
    localparam logic [2:0] E_PROTO    = 3'd3;
    localparam logic [2:0] E_TIMEOUT  = 3'd4;
    localparam logic [2:0] E_OUTSIDE  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_WINDOW, S_EXPIRED} state_t;

    logic                  r_q_wr   [DEPTH];
    logic [ADDR_WIDTH-1:0] r_q_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_q_data [DEPTH];
    logic [PW-1:0]         r_wp, r_rp;
    logic [LW-1:0]         r_cnt;
    state_t                r_state, w_state_nxt;
    logic [TW-1:0]         r_timer, w_timer_nxt;
    logic                  r_stall_d;
    logic                  r_err_valid;
    logic [2:0]            r_err_code;
    logic [CNT_WIDTH-1:0]  r_match_cnt, r_err_cnt;

    logic                  w_full, w_empty, w_push, w_txn, w_proto, w_pop, w_hit, w_match, w_outside, w_timeout;
    logic [ADDR_WIDTH-1:0] w_obs_addr;
    logic [2:0]            w_err_code;

    assign w_full     = r_cnt == LW'(DEPTH);
    assign w_empty    = r_cnt == '0;
    assign w_push     = sb.exp_valid && !w_full;
    assign w_txn      = sb.exec_rd_req ^ sb.exec_wr_req;
    assign w_proto    = sb.exec_rd_req && sb.exec_wr_req;
    assign w_pop      = w_txn && !w_empty;
    assign w_obs_addr = sb.exec_wr_req ? sb.exec_wr_addr : sb.exec_rd_addr;
    assign w_hit      = (r_q_wr[r_rp] == sb.exec_wr_req) && (r_q_addr[r_rp] == w_obs_addr) &&
                        (!sb.exec_wr_req || r_q_data[r_rp] == sb.exec_wr_data);
    assign w_match    = w_pop && w_hit;
    assign w_outside  = w_txn && r_state == S_IDLE && !sb.stall;
    assign w_err_code = w_proto            ? E_PROTO    :
                        (w_pop && !w_hit)  ? E_MISMATCH :
                        (w_txn && w_empty) ? E_UNEXP    :
                        w_outside          ? E_OUTSIDE  :
                        w_timeout          ? E_TIMEOUT  : 3'd0;

    assign sb.exp_ready = !w_full;
    assign sb.err_valid = r_err_valid;
    assign sb.err_code  = r_err_code;
    assign sb.match_cnt = r_match_cnt;
    assign sb.err_cnt   = r_err_cnt;
    assign sb.q_level   = r_cnt;
    assign sb.busy      = !w_empty || r_state != S_IDLE;

    // Queue payload storage; contents are don't-care until pointed at, so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_wr[r_wp]   <= sb.exp_is_wr;
            r_q_addr[r_wp] <= sb.exp_addr;
            r_q_data[r_wp] <= sb.exp_data;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop) r_rp <= r_rp + PW'(1);
            r_cnt <= r_cnt + LW'(w_push) - LW'(w_pop);
        end
    end

    // Stall-window FSM state, timer and stall edge detector
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_stall_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_stall_d <= sb.stall;
        end
    end

    // Stall-window next state: one TIMEOUT per window, then hold in EXPIRED until stall drops
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sb.stall && !r_stall_d) begin
                    w_state_nxt = S_WINDOW;
                    w_timer_nxt = TW'(1);
                end
            end
            S_WINDOW: begin
                if (!sb.stall) w_state_nxt = S_IDLE;
                else if (r_timer == TW'(TIMEOUT)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_EXPIRED;
                end else w_timer_nxt = r_timer + TW'(1);
            end
            S_EXPIRED: begin
                if (!sb.stall) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered error report and saturating statistics counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_valid <= 1'b0;
            r_err_code  <= 3'd0;
            r_match_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_err_valid <= w_err_code != 3'd0;
            r_err_code  <= w_err_code;
            if (w_match && !(&r_match_cnt)) r_match_cnt <= r_match_cnt + CNT_WIDTH'(1);
            if (w_err_code != 3'd0 && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_exec_txn_scoreboard.sv
// tb_exec_txn_scoreboard: directed checks of queue compare, error priority, stall timeout and async reset
`timescale 1ns/1ps
module tb_exec_txn_scoreboard;
    localparam int AW = 12;
    localparam int DW = 12;
    localparam int DEPTH = 8;
    localparam int TIMEOUT = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int passes = 0;
    int pulses = 0;
    logic [2:0] last_code = 3'd0;

    exec_txn_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

    exec_txn_scoreboard #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sb(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.exp_valid = 1'b1;
        bus.exp_is_wr = w;
        bus.exp_addr  = a;
        bus.exp_data  = d;
        cyc();
        bus.exp_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        bus.exec_rd_req  = 1'b1;
        bus.exec_rd_addr = a;
        cyc();
        bus.exec_rd_req = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.exec_wr_req  = 1'b1;
        bus.exec_wr_addr = a;
        bus.exec_wr_data = d;
        cyc();
        bus.exec_wr_req = 1'b0;
    endtask

    task automatic push_rd(input logic [AW-1:0] pa, input logic [AW-1:0] ra);
        bus.exp_valid    = 1'b1;
        bus.exp_is_wr    = 1'b0;
        bus.exp_addr     = pa;
        bus.exp_data     = '0;
        bus.exec_rd_req  = 1'b1;
        bus.exec_rd_addr = ra;
        cyc();
        bus.exp_valid   = 1'b0;
        bus.exec_rd_req = 1'b0;
    endtask

    initial begin
        bus.exp_valid = 0; bus.exp_is_wr = 0; bus.exp_addr = '0; bus.exp_data = '0;
        bus.exec_rd_req = 0; bus.exec_rd_addr = '0; bus.exec_wr_req = 0;
        bus.exec_wr_addr = '0; bus.exec_wr_data = '0; bus.stall = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_err_valid", 32'(bus.err_valid), 0);
        chk("rst_err_code", 32'(bus.err_code), 0);
        chk("rst_match_cnt", 32'(bus.match_cnt), 0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 0);
        chk("rst_q_level", 32'(bus.q_level), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_exp_ready", 32'(bus.exp_ready), 1);
        reset_n = 1'b1;
        cyc();

        bus.stall = 1'b1;
        cyc();
        chk("t1_busy_window", 32'(bus.busy), 1);
        push(1'b0, 12'o100, '0);
        chk("t1_level_after_push", 32'(bus.q_level), 1);
        rd(12'o100);
        chk("t1_match_cnt", 32'(bus.match_cnt), 1);
        chk("t1_no_err", 32'(bus.err_valid), 0);
        chk("t1_level_after_pop", 32'(bus.q_level), 0);
        bus.stall = 1'b0;
        cyc();

        push(1'b1, 12'o200, 12'o7);
        wr(12'o200, 12'o6);
        chk("t2_err_valid", 32'(bus.err_valid), 1);
        chk("t2_err_code", 32'(bus.err_code), 1);
        chk("t2_err_cnt", 32'(bus.err_cnt), 1);
        chk("t2_level", 32'(bus.q_level), 0);
        chk("t2_match_cnt", 32'(bus.match_cnt), 1);
        cyc();
        chk("t2_pulse_ends", 32'(bus.err_valid), 0);

        for (int i = 0; i < 8; i++) push(1'b0, 12'(12'o10 + i), '0);
        chk("t3_full_level", 32'(bus.q_level), 8);
        chk("t3_full_ready", 32'(bus.exp_ready), 0);
        push(1'b0, 12'o77, '0);
        chk("t3_drop_level", 32'(bus.q_level), 8);
        rd(12'o10);
        chk("t3_pop_match", 32'(bus.match_cnt), 2);
        chk("t3_outside_code", 32'(bus.err_code), 5);
        chk("t3_pop_level", 32'(bus.q_level), 7);
        push_rd(12'o20, 12'o11);
        chk("t3_pushpop_level", 32'(bus.q_level), 7);
        for (int i = 2; i < 8; i++) rd(12'(12'o10 + i));
        rd(12'o20);
        chk("t3_drain_match", 32'(bus.match_cnt), 10);
        chk("t3_drain_level", 32'(bus.q_level), 0);
        push(1'b0, 12'o400, '0);
        for (int i = 1; i < 12; i++) push_rd(12'(12'o400 + i), 12'(12'o400 + i - 1));
        chk("t3_wrap_level", 32'(bus.q_level), 1);
        rd(12'o413);
        chk("t3_wrap_match", 32'(bus.match_cnt), 22);
        chk("t3_wrap_err_cnt", 32'(bus.err_cnt), 22);
        chk("t3_wrap_empty", 32'(bus.q_level), 0);

        bus.stall = 1'b1;
        cyc();
        chk("t4_busy_stall", 32'(bus.busy), 1);
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (bus.err_valid) begin
                pulses++;
                last_code = bus.err_code;
            end
        end
        bus.stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            if (bus.err_valid) begin
                pulses++;
                last_code = bus.err_code;
            end
        end
        chk("t4_pulse_count", 32'(pulses), 1);
        chk("t4_code", 32'(last_code), 4);
        chk("t4_err_cnt", 32'(bus.err_cnt), 23);
        chk("t4_idle_busy", 32'(bus.busy), 0);

        push(1'b0, 12'o300, '0);
        bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o300;
        bus.exec_wr_req = 1'b1; bus.exec_wr_addr = 12'o300; bus.exec_wr_data = '0;
        cyc();
        bus.exec_rd_req = 1'b0; bus.exec_wr_req = 1'b0;
        chk("t5_proto_code", 32'(bus.err_code), 3);
        chk("t5_proto_level", 32'(bus.q_level), 1);
        chk("t5_proto_err_cnt", 32'(bus.err_cnt), 24);
        rd(12'o300);
        chk("t5_drain_match", 32'(bus.match_cnt), 23);
        rd(12'o300);
        chk("t5_unexp_code", 32'(bus.err_code), 2);
        chk("t5_unexp_err_cnt", 32'(bus.err_cnt), 26);
        chk("t5_unexp_match", 32'(bus.match_cnt), 23);

        for (int i = 0; i < 3; i++) push(1'b0, 12'(12'o500 + i), '0);
        bus.stall = 1'b1;
        bus.exec_rd_req = 1'b1; bus.exec_wr_req = 1'b1;
        cyc();
        bus.exec_rd_req = 1'b0; bus.exec_wr_req = 1'b0;
        chk("t6_pre_err", 32'(bus.err_valid), 1);
        chk("t6_pre_level", 32'(bus.q_level), 3);
        reset_n = 1'b0;
        #1;
        chk("t6_err_valid", 32'(bus.err_valid), 0);
        chk("t6_err_code", 32'(bus.err_code), 0);
        chk("t6_q_level", 32'(bus.q_level), 0);
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_exp_ready", 32'(bus.exp_ready), 1);
        chk("t6_match_cnt", 32'(bus.match_cnt), 0);
        chk("t6_err_cnt", 32'(bus.err_cnt), 0);
        bus.stall = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
